// File: rtl/lut_writer_pkg.sv
// Shared encodings for the key/data table writer: request ops, response status, FSM states.
package lut_writer_pkg;

    typedef enum logic [1:0] {
        OP_NOP    = 2'd0,
        OP_INSERT = 2'd1,
        OP_DELETE = 2'd2,
        OP_CLEAR  = 2'd3
    } op_e;

    typedef enum logic [1:0] {
        ST_OK        = 2'd0,
        ST_NOT_FOUND = 2'd1,
        ST_FULL      = 2'd2,
        ST_BAD_KEY   = 2'd3
    } status_e;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SCAN   = 2'd1,
        COMMIT = 2'd2,
        RESP   = 2'd3
    } state_e;

endpackage

// File: rtl/lut_table_writer.sv
// Programmable key/data table with a sequential search; drives the packed lut bus
// consumed by the key-lookup mux.
module lut_table_writer
    import lut_writer_pkg::*;
#(
    parameter int              NR_KEY   = 4,
    parameter int              KEY_LEN  = 4,
    parameter int              DATA_LEN = 8,
    parameter logic [KEY_LEN-1:0] FREE_KEY = '1,
    localparam int PAIR_LEN = KEY_LEN + DATA_LEN,
    localparam int IDX_W    = (NR_KEY > 2) ? $clog2(NR_KEY) : 1,
    localparam int CNT_W    = $clog2(NR_KEY + 1)
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       req_valid,
    output logic                       req_ready,
    input  logic [1:0]                 req_op,
    input  logic [KEY_LEN-1:0]         req_key,
    input  logic [DATA_LEN-1:0]        req_data,
    output logic                       resp_valid,
    input  logic                       resp_ready,
    output logic [1:0]                 resp_status,
    output logic                       resp_hit,
    output logic [IDX_W-1:0]           resp_index,
    output logic [NR_KEY*PAIR_LEN-1:0] lut,
    output logic [NR_KEY-1:0]          valid_mask,
    output logic [CNT_W-1:0]           count
);

    state_e state, state_nx;

    logic [NR_KEY-1:0][KEY_LEN-1:0]  keys;
    logic [NR_KEY-1:0][DATA_LEN-1:0] datas;
    logic [NR_KEY-1:0]               valid;

    logic [1:0]          op_q;
    logic [KEY_LEN-1:0]  key_q;
    logic [DATA_LEN-1:0] data_q;
    logic [IDX_W-1:0]    scan_idx;
    logic                match_found;
    logic [IDX_W-1:0]    match_idx;
    logic                free_found;
    logic [IDX_W-1:0]    free_idx;

    logic hit_now;
    logic scan_last;
    logic bad_key;

    assign hit_now   = valid[scan_idx] && (keys[scan_idx] == key_q);
    assign scan_last = (scan_idx == IDX_W'(NR_KEY - 1));
    assign bad_key   = ((req_op == OP_INSERT) || (req_op == OP_DELETE)) && (req_key == FREE_KEY);

    assign req_ready  = (state == IDLE) && !rst;
    assign resp_valid = (state == RESP);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE: begin
                if (req_valid) begin
                    if (req_op == OP_NOP || bad_key) state_nx = RESP;
                    else if (req_op == OP_CLEAR)     state_nx = COMMIT;
                    else                             state_nx = SCAN;
                end
            end
            SCAN:    if (hit_now || scan_last) state_nx = COMMIT;
            COMMIT:  state_nx = RESP;
            RESP:    if (resp_ready) state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            keys        <= '0;
            datas       <= '0;
            valid       <= '0;
            count       <= '0;
            op_q        <= '0;
            key_q       <= '0;
            data_q      <= '0;
            scan_idx    <= '0;
            match_found <= 1'b0;
            match_idx   <= '0;
            free_found  <= 1'b0;
            free_idx    <= '0;
            resp_status <= '0;
            resp_hit    <= 1'b0;
            resp_index  <= '0;
        end else begin
            case (state)
                IDLE: begin
                    // rst is low here, so req_valid alone means the handshake fires
                    if (req_valid) begin
                        op_q        <= req_op;
                        key_q       <= req_key;
                        data_q      <= req_data;
                        scan_idx    <= '0;
                        match_found <= 1'b0;
                        match_idx   <= '0;
                        free_found  <= 1'b0;
                        free_idx    <= '0;
                        resp_status <= bad_key ? ST_BAD_KEY : ST_OK;
                        resp_hit    <= 1'b0;
                        resp_index  <= '0;
                    end
                end
                SCAN: begin
                    if (hit_now) begin
                        match_found <= 1'b1;
                        match_idx   <= scan_idx;
                    end else if (!valid[scan_idx] && !free_found) begin
                        free_found <= 1'b1;
                        free_idx   <= scan_idx;
                    end
                    if (!scan_last) scan_idx <= scan_idx + IDX_W'(1);
                end
                COMMIT: begin
                    case (op_q)
                        OP_CLEAR: begin
                            valid       <= '0;
                            count       <= '0;
                            resp_status <= ST_OK;
                        end
                        OP_INSERT: begin
                            if (match_found) begin
                                datas[match_idx] <= data_q;
                                resp_status      <= ST_OK;
                                resp_hit         <= 1'b1;
                                resp_index       <= match_idx;
                            end else if (free_found) begin
                                keys[free_idx]  <= key_q;
                                datas[free_idx] <= data_q;
                                valid[free_idx] <= 1'b1;
                                count           <= count + CNT_W'(1);
                                resp_status     <= ST_OK;
                                resp_index      <= free_idx;
                            end else begin
                                resp_status <= ST_FULL;
                            end
                        end
                        OP_DELETE: begin
                            if (match_found) begin
                                valid[match_idx] <= 1'b0;
                                count            <= count - CNT_W'(1);
                                resp_status      <= ST_OK;
                                resp_hit         <= 1'b1;
                                resp_index       <= match_idx;
                            end else begin
                                resp_status <= ST_NOT_FOUND;
                            end
                        end
                        default: resp_status <= ST_OK;
                    endcase
                end
                default: ;
            endcase
        end
    end

    // Empty slots advertise the reserved key so the lookup mux can never match them.
    for (genvar n = 0; n < NR_KEY; n++) begin : g_pack
        assign lut[PAIR_LEN*n +: PAIR_LEN] = valid[n] ? {keys[n], datas[n]}
                                                      : {FREE_KEY, {DATA_LEN{1'b0}}};
        assign valid_mask[n] = valid[n];
    end

endmodule

// File: tb/tb_lut_table_writer.sv
// Scoreboard bench for lut_table_writer: a behavioural table model predicts every response.
module tb_lut_table_writer;
    import lut_writer_pkg::*;

    localparam int NR = 4;
    localparam int KL = 4;
    localparam int DL = 8;
    localparam int PL = KL + DL;
    localparam int IW = 2;
    localparam int CW = 3;

    logic              clk = 1'b0;
    logic              rst;
    logic              req_valid;
    logic              req_ready;
    logic [1:0]        req_op;
    logic [KL-1:0]     req_key;
    logic [DL-1:0]     req_data;
    logic              resp_valid;
    logic              resp_ready;
    logic [1:0]        resp_status;
    logic              resp_hit;
    logic [IW-1:0]     resp_index;
    logic [NR*PL-1:0]  lut;
    logic [NR-1:0]     valid_mask;
    logic [CW-1:0]     count;

    always #5 clk = ~clk;

    lut_table_writer #(.NR_KEY(NR), .KEY_LEN(KL), .DATA_LEN(DL)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
        .req_key(req_key), .req_data(req_data),
        .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_status(resp_status),
        .resp_hit(resp_hit), .resp_index(resp_index),
        .lut(lut), .valid_mask(valid_mask), .count(count)
    );

    typedef struct {
        logic [1:0]       st;
        logic             hit;
        logic [IW-1:0]    idx;
        logic [CW-1:0]    cnt;
        logic [NR*PL-1:0] lut;
        logic [NR-1:0]    mask;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;
    int n_cmp = 0;
    int n_err = 0;

    logic [KL-1:0] mk[NR];
    logic [DL-1:0] md[NR];
    logic          mv[NR];
    int            mcnt;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h want %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [NR*PL-1:0] model_lut();
        logic [NR*PL-1:0] r;
        for (int i = 0; i < NR; i++)
            r[i*PL +: PL] = mv[i] ? {mk[i], md[i]} : {4'hF, 8'h00};
        return r;
    endfunction

    task automatic model_clear();
        for (int i = 0; i < NR; i++) begin
            mv[i] = 1'b0; mk[i] = '0; md[i] = '0;
        end
        mcnt = 0;
    endtask

    always @(negedge clk) begin
        if (resp_valid && resp_ready) begin
            if (sb.size() == 0) begin
                chk("spurious_resp", 1, 0);
            end else begin
                mon_e = sb.pop_front();
                chk("status", resp_status, mon_e.st);
                chk("hit", resp_hit, mon_e.hit);
                chk("index", resp_index, mon_e.idx);
                chk("count", count, mon_e.cnt);
                chk("lut", lut, mon_e.lut);
                chk("valid_mask", valid_mask, mon_e.mask);
            end
        end
    end

    task automatic do_req(input logic [1:0] op, input logic [KL-1:0] key,
                          input logic [DL-1:0] data, input int stall);
        exp_t e;
        int m, f, lat, cyc;
        bit got;
        logic [1:0] s_st;
        logic s_hit;
        logic [IW-1:0] s_idx;
        m = -1; f = -1;
        for (int i = 0; i < NR; i++) if (m < 0 && mv[i] && mk[i] == key) m = i;
        for (int i = 0; i < NR; i++) if (f < 0 && !mv[i]) f = i;
        e.st = ST_OK; e.hit = 1'b0; e.idx = '0; lat = 0;
        if (op == OP_CLEAR) begin
            model_clear();
            lat = 1;
        end else if (op == OP_INSERT || op == OP_DELETE) begin
            if (key == 4'hF) begin
                e.st = ST_BAD_KEY;
            end else begin
                lat = (m >= 0) ? m + 2 : NR + 1;
                if (op == OP_INSERT) begin
                    if (m >= 0) begin
                        md[m] = data; e.hit = 1'b1; e.idx = IW'(m);
                    end else if (f >= 0) begin
                        mk[f] = key; md[f] = data; mv[f] = 1'b1; mcnt++; e.idx = IW'(f);
                    end else begin
                        e.st = ST_FULL;
                    end
                end else begin
                    if (m >= 0) begin
                        mv[m] = 1'b0; mcnt--; e.hit = 1'b1; e.idx = IW'(m);
                    end else begin
                        e.st = ST_NOT_FOUND;
                    end
                end
            end
        end
        e.cnt = CW'(mcnt);
        e.lut = model_lut();
        for (int i = 0; i < NR; i++) e.mask[i] = mv[i];
        sb.push_back(e);

        if (stall > 0) resp_ready = 1'b0;
        req_op = op; req_key = key; req_data = data; req_valid = 1'b1;
        @(negedge clk);
        chk("req_ready_idle", req_ready, 1);
        @(posedge clk);
        #1 req_valid = 1'b0;
        cyc = 0; got = 1'b0;
        while (cyc < 40) begin
            @(negedge clk);
            if (resp_valid) begin got = 1'b1; break; end
            cyc++;
        end
        if (!got) begin
            chk("resp_timeout", 0, 1);
            void'(sb.pop_back());
            resp_ready = 1'b1;
            return;
        end
        chk("latency", cyc, lat);
        if (stall > 0) begin
            s_st = resp_status; s_hit = resp_hit; s_idx = resp_index;
            for (int i = 0; i < stall; i++) begin
                @(negedge clk);
                chk("stall_valid", resp_valid, 1);
                chk("stall_ready", req_ready, 0);
                chk("stall_status", resp_status, s_st);
                chk("stall_hit", resp_hit, s_hit);
                chk("stall_index", resp_index, s_idx);
            end
            @(posedge clk);
            #1 resp_ready = 1'b1;
            @(negedge clk);
            @(posedge clk);
            #1;
            @(negedge clk);
            chk("idle_after_release", req_ready, 1);
            chk("resp_dropped", resp_valid, 0);
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int seen;
        logic [1:0] rop;
        logic [KL-1:0] rkey;
        model_clear();
        rst = 1'b1; req_valid = 1'b0; req_op = '0; req_key = '0; req_data = '0;
        resp_ready = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("ready_in_rst", req_ready, 0);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("rst_resp_valid", resp_valid, 0);
        chk("rst_req_ready", req_ready, 1);
        chk("rst_count", count, 0);
        chk("rst_mask", valid_mask, 0);
        chk("rst_lut", lut, 48'hF00F00F00F00);
        chk("rst_status", resp_status, 0);
        chk("rst_hit", resp_hit, 0);
        chk("rst_index", resp_index, 0);
        @(posedge clk); #1;

        do_req(OP_INSERT, 4'h3, 8'hA5, 0);
        chk("pair0_3A5", lut[11:0], 12'h3A5);
        chk("upper_free", lut[47:12], 36'hF00F00F00);
        do_req(OP_INSERT, 4'h3, 8'h5A, 0);
        chk("pair0_35A", lut[11:0], 12'h35A);

        do_req(OP_CLEAR, 4'h0, 8'h00, 0);
        do_req(OP_INSERT, 4'h1, 8'h11, 0);
        do_req(OP_INSERT, 4'h2, 8'h22, 0);
        do_req(OP_INSERT, 4'h3, 8'h33, 0);
        do_req(OP_INSERT, 4'h4, 8'h44, 0);
        do_req(OP_INSERT, 4'h7, 8'h77, 0);
        chk("full_status", resp_status, ST_FULL);
        chk("full_count", count, 4);
        do_req(OP_DELETE, 4'h2, 8'h00, 0);
        chk("del2_index", resp_index, 1);
        do_req(OP_INSERT, 4'h7, 8'h77, 0);
        chk("key7_slot1", lut[23:12], 12'h777);

        do_req(OP_DELETE, 4'h3, 8'h00, 0);
        do_req(OP_DELETE, 4'h9, 8'h00, 0);
        chk("del9_status", resp_status, ST_NOT_FOUND);
        do_req(OP_INSERT, 4'hF, 8'hEE, 0);
        do_req(OP_DELETE, 4'hF, 8'h00, 0);
        do_req(OP_NOP, 4'h5, 8'h55, 0);

        do_req(OP_DELETE, 4'h4, 8'h00, 5);
        do_req(OP_INSERT, 4'h6, 8'h66, 3);
        do_req(OP_CLEAR, 4'h0, 8'h00, 0);
        chk("clear_mask", valid_mask, 0);
        chk("clear_count", count, 0);

        for (int i = 0; i < 30; i++) begin
            rop = 2'($urandom_range(0, 3));
            if (rop == OP_CLEAR && $urandom_range(0, 3) != 0) rop = OP_INSERT;
            rkey = 4'($urandom_range(0, 6));
            if (rkey == 4'h6) rkey = 4'hF;
            do_req(rop, rkey, 8'($urandom), 0);
        end

        do_req(OP_INSERT, 4'h8, 8'h88, 0);
        req_op = OP_DELETE; req_key = 4'h9; req_data = '0; req_valid = 1'b1;
        @(posedge clk);
        #1 req_valid = 1'b0;
        @(posedge clk);
        #1 rst = 1'b1;
        #1;
        chk("midrst_mask", valid_mask, 0);
        chk("midrst_count", count, 0);
        chk("midrst_resp", resp_valid, 0);
        chk("midrst_lut", lut, 48'hF00F00F00F00);
        model_clear();
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("post_rst_ready", req_ready, 1);
        seen = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            seen += int'(resp_valid);
        end
        chk("no_resp_after_rst", seen, 0);
        @(posedge clk); #1;
        do_req(OP_INSERT, 4'h2, 8'hC3, 0);
        chk("post_rst_pair0", lut[11:0], 12'h2C3);
        chk("sb_drained", sb.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
